// File: rtl/fft_sdp_ram_if.sv
// Port bundle for fft_sdp_ram: one write port and one read port.
// The read side carries an optional output-register clock enable.
interface fft_sdp_ram_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_oce;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, rd_oce,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, rd_oce,
        output rd_data
    );
endinterface

// File: rtl/fft_sdp_ram.sv
// Simple dual-port block RAM that buffers FFT words between pipeline stages.
// Reads are read-first. An optional output register adds one cycle of latency.
module fft_sdp_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter bit OUTPUT_REG = 1'b0,
    parameter bit RD_OCE_EN  = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    fft_sdp_ram_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q_p1;

    // The write port has no reset so that the array still maps onto block RAM.
    // rst_n only suppresses the write strobe.
    always_ff @(posedge clk) begin
        if (rst_n && bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Stage p1: array read, registered every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q_p1 <= '0;
        end else begin
            rd_q_p1 <= mem[bus.rd_addr];
        end
    end

    generate
        if (OUTPUT_REG) begin : g_oreg
            logic [DATA_WIDTH-1:0] rd_q_p2;
            logic                  oce;

            assign oce = RD_OCE_EN ? bus.rd_oce : 1'b1;

            // Stage p2: optional output register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_q_p2 <= '0;
                end else if (oce) begin
                    rd_q_p2 <= rd_q_p1;
                end
            end

            assign bus.rd_data = rd_q_p2;
        end else begin : g_noreg
            logic unused_oce;

            assign unused_oce  = bus.rd_oce;
            assign bus.rd_data = rd_q_p1;
        end
    endgenerate
endmodule

// File: tb/tb_fft_sdp_ram.sv
// Bench for fft_sdp_ram. It drives two instances from the same stimulus: one with latency 1,
// and one with the output register and rd_oce gating enabled.
module tb_fft_sdp_ram;
    localparam int AW = 8;
    localparam int DW = 64;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fft_sdp_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b0 ();
    fft_sdp_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();

    fft_sdp_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1'b0), .RD_OCE_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
    );
    fft_sdp_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTPUT_REG(1'b1), .RD_OCE_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );

    int checks = 0;
    int failures = 0;

    // Reference model. The memory is an array, and "known" marks words that have been written.
    // q_exp is the word read at the last edge. o_exp is the word that the gated output stage presents.
    logic [DW-1:0] mdl   [DEPTH];
    bit            known [DEPTH];
    logic [DW-1:0] q_exp, o_exp;
    bit            q_ok, o_ok;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q_exp = '0; q_ok = 1'b1;
        o_exp = '0; o_ok = 1'b1;
    endtask

    // One clock cycle: drive the ports, update the model at the edge, then check 1 time unit later.
    task automatic step(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [AW-1:0] ra, input bit oce, input string tag);
        b0.wr_en = we; b0.wr_addr = wa; b0.wr_data = wd; b0.rd_addr = ra; b0.rd_oce = 1'b1;
        b1.wr_en = we; b1.wr_addr = wa; b1.wr_data = wd; b1.rd_addr = ra; b1.rd_oce = oce;
        @(posedge clk);
        if (rst_n) begin
            if (oce) begin
                o_exp = q_exp; o_ok = q_ok;
            end
            q_exp = mdl[ra]; q_ok = known[ra];
            if (we) begin
                mdl[wa] = wd; known[wa] = 1'b1;
            end
        end
        #1;
        if (q_ok) chk({tag, "_lat1"}, b0.rd_data, q_exp);
        if (o_ok) chk({tag, "_lat2"}, b1.rd_data, o_exp);
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        logic [DW-1:0] v255, v0, old7;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        // 1: reset held for 200 ns, then random traffic
        rst_n = 1'b0;
        b0.wr_en = 1'b0; b0.wr_addr = '0; b0.wr_data = '0; b0.rd_addr = '0; b0.rd_oce = 1'b1;
        b1.wr_en = 1'b0; b1.wr_addr = '0; b1.wr_data = '0; b1.rd_addr = '0; b1.rd_oce = 1'b1;
        model_reset();
        #100;
        chk("rst_hold_lat1", b0.rd_data, '0);
        chk("rst_hold_lat2", b1.rd_data, '0);
        #100;
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++)
            step(1'b1, AW'($urandom_range(0, 15)), rnd64(), AW'($urandom_range(0, 15)), 1'b1, "post_rst");

        // 2: fill every address, then read back to back
        for (int a = 0; a < DEPTH; a++)
            step(1'b1, AW'(a), 64'hFFFF_FFFF_FFFF_FFFF - 64'(a), AW'(a), 1'b1, "fill");
        for (int a = 0; a < DEPTH; a++)
            step(1'b0, '0, '0, AW'(a), 1'b1, "readback");
        step(1'b0, '0, '0, 8'd0, 1'b1, "readback_tail");
        chk("readback_last", b1.rd_data, 64'hFFFF_FFFF_FFFF_FFFF - 64'd255);

        // 3: read-during-write to the same address returns the old word
        step(1'b1, 8'd5, 64'h1234, 8'd0, 1'b1, "rdw_pre");
        step(1'b1, 8'd5, 64'hABCD, 8'd5, 1'b1, "rdw_same");
        chk("rdw_old", b0.rd_data, 64'h1234);
        step(1'b0, '0, '0, 8'd5, 1'b1, "rdw_reread");
        chk("rdw_new", b0.rd_data, 64'hABCD);

        // 4: stream reads of addresses 0..3, then hold the output register for 2 cycles
        for (int a = 0; a < 4; a++) step(1'b0, '0, '0, AW'(a), 1'b1, "oce_stream");
        step(1'b0, '0, '0, 8'd10, 1'b0, "oce_hold");
        step(1'b0, '0, '0, 8'd11, 1'b0, "oce_hold");
        step(1'b0, '0, '0, 8'd12, 1'b1, "oce_resume");
        step(1'b0, '0, '0, 8'd13, 1'b1, "oce_resume");

        // Random mix of writes, reads and rd_oce
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), AW'($urandom()), rnd64(), AW'($urandom()),
                 1'($urandom_range(0, 3) != 0), "random");

        // 5: asynchronous reset between edges while writes to address 7 are attempted
        old7 = mdl[7];
        for (int i = 0; i < 4; i++) step(1'b1, AW'(20 + i), rnd64(), AW'(i), 1'b1, "pre_async");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_lat1", b0.rd_data, '0);
        chk("async_rst_lat2", b1.rd_data, '0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'd7, 64'hDEAD, 8'd7, 1'b1, "in_rst");
        rst_n = 1'b1;
        step(1'b0, '0, '0, 8'd7, 1'b1, "post_async");
        chk("addr7_kept", b0.rd_data, old7);
        for (int a = 20; a < 26; a++) step(1'b0, '0, '0, AW'(a), 1'b1, "post_async");

        // 6: wrap between the highest address and the lowest
        v255 = rnd64();
        v0   = rnd64();
        step(1'b1, 8'd255, v255, 8'd1, 1'b1, "wrap_w");
        step(1'b1, 8'd0,   v0,   8'd2, 1'b1, "wrap_w");
        step(1'b0, '0, '0, 8'd255, 1'b1, "wrap_r");
        chk("wrap_255", b0.rd_data, v255);
        step(1'b0, '0, '0, 8'd0, 1'b1, "wrap_r");
        chk("wrap_0", b0.rd_data, v0);
        step(1'b0, '0, '0, 8'd0, 1'b1, "wrap_r");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_sdp_ram.md
Name: fft_sdp_ram

Overview:
- Simple dual-port synchronous RAM: one write port, one read port, single clock domain.
- Buffers FFT sample/twiddle words between pipeline stages: 256 words x 64 bits by default.
- The read port always reads, with 1-cycle latency (2 cycles with the optional output register).
- Memory array maps to block RAM. Reset clears only the read-path registers.

Parameters:
- ADDR_WIDTH, 8, address width for both ports; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 64, word width for both ports.
- OUTPUT_REG, 0, 1 adds a second read pipeline register (latency 2).
- RD_OCE_EN, 0, 1 makes rd_oce gate the output register; ignored when OUTPUT_REG=0.

Ports:
- clk  input  1  single clock; all ports are sampled on its rising edge.
- rst_n  input  1  asynchronous active-low reset. Clears the read-data registers only; memory contents are untouched.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- rd_addr  input  ADDR_WIDTH  read address, sampled every cycle.
- rd_oce  input  1  output-register clock enable. Used only when OUTPUT_REG=1 and RD_OCE_EN=1; tie high otherwise.
- rd_data  output  DATA_WIDTH  read data.

Behaviour:
- Storage: mem[0 .. 2**ADDR_WIDTH-1], DATA_WIDTH each. No initialisation file; contents are undefined until written (simulation may show X).
- Write: on a rising clk with rst_n=1 and wr_en=1, mem[wr_addr] <= wr_data. No byte enables; the whole word is written.
- Write during reset: while rst_n=0, writes are ignored.
- Read stage 1 (always present): on every rising clk, q1 <= mem[rd_addr]. There is no read enable.
- OUTPUT_REG=0: rd_data = q1. Data for the address presented at edge N is valid after edge N.
- OUTPUT_REG=1: q2 <= q1 each rising edge, and rd_data = q2 (latency 2).
  - When RD_OCE_EN=1, q2 updates only when rd_oce=1; otherwise q2 holds.
- Reset: rst_n low asynchronously forces q1 and q2 to 0, so rd_data = 0 immediately. Release is synchronous to the next rising edge; normal reads resume that edge.
- Read-during-write, same address, same edge: read-first. q1 returns the old contents; the new data is visible on the next read.
- Different addresses on the two ports: fully independent; one write and one read complete every cycle.
- Addresses wrap naturally; there is no out-of-range condition.
- Throughput: one write plus one read per clock, sustained, with no bubbles.

Test Plan:
1. Hold rst_n=0 for 200 ns, then release.
   - During reset: rd_data=0.
   - After release: rd_data follows mem[rd_addr] one edge later, regardless of the write port.
2. Fill all 256 addresses with data = 64'hFFFF_FFFF_FFFF_FFFF - addr, then read addresses 0..255 back-to-back.
   - Response: rd_data = 64'hFFFF_FFFF_FFFF_FFFF - addr, one cycle after each address (OUTPUT_REG=0), with zero mismatches.
3. Write 64'h1234 to address 5, then on the same edge write 64'hABCD to address 5 while reading address 5.
   - Response: rd_data = 64'h1234 next cycle; re-reading address 5 gives 64'hABCD.
4. OUTPUT_REG=1, RD_OCE_EN=1: stream reads of addresses 0..3 with rd_oce=1, then drop rd_oce for 2 cycles.
   - Response: latency of 2 cycles; rd_data holds its value while rd_oce=0.
5. Assert rst_n=0 mid-stream, asynchronously between edges, while pulsing wr_en to address 7 with 64'hDEAD.
   - Response: rd_data=0 immediately; address 7 keeps its prior value; earlier memory contents are intact after release.
6. Wrap: write address 255 then address 0 consecutively, then read 255 and 0.
   - Response: both values are returned correctly, with no aliasing.
